// File: rtl/vlane_alu_seq.sv
// vlane_alu_seq: masked vector integer ALU that strip-mines one VLEN-bit operation over LANES x ELEN bits per beat
module vlane_alu_seq #(
  parameter int VLEN = 128,
  parameter int ELEN = 32,
  parameter int LANES = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [2:0]                 op,
  input  logic [1:0]                 opd_sel,
  input  logic [1:0]                 sew,
  input  logic                       vm,
  input  logic [$clog2(VLEN/8):0]    vl,
  input  logic [VLEN-1:0]            vs1,
  input  logic [VLEN-1:0]            vs2,
  input  logic [VLEN-1:0]            vd_old,
  input  logic [VLEN-1:0]            v0,
  input  logic [ELEN-1:0]            rs1,
  input  logic [4:0]                 imm5,
  output logic                       busy,
  output logic                       done,
  output logic [VLEN-1:0]            vd
);
  localparam int BW = LANES * ELEN;
  localparam int BEATS = VLEN / BW;
  localparam int CW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int VLW = $clog2(VLEN / 8) + 1;
  localparam int IW = $clog2(VLEN);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;
  logic [2:0] op_r;
  logic [1:0] opd_r, sew_r;
  logic vm_r, zero_r, acc, last;
  logic [VLW-1:0] evl_r, vlmax;
  logic [VLEN-1:0] vs1_r, vs2_r, old_r, v0_r;
  logic [ELEN-1:0] rs1_r;
  logic [4:0] imm_r;
  logic [CW-1:0] beat;
  logic [BW-1:0] a_s, b_s, o_s, res;
  logic [BW-1:0] r_w [3];
  assign acc = state == IDLE && start;
  assign last = zero_r || beat == CW'(BEATS - 1);
  assign busy = state == RUN;
  assign vlmax = sew == 2'b00 ? VLW'(VLEN / 8) : sew == 2'b01 ? VLW'(VLEN / 16) : VLW'(VLEN / 32);
  assign a_s = vs2_r[beat*BW +: BW];
  assign b_s = vs1_r[beat*BW +: BW];
  assign o_s = old_r[beat*BW +: BW];
  assign res = sew_r == 2'b00 ? r_w[0] : sew_r == 2'b01 ? r_w[1] : r_w[2];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    state_nx = acc ? RUN : (busy && last) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      beat <= '0;
      done <= 1'b0;
      vd <= '0;
    end else begin
      done <= busy && last;
      beat <= busy && !last ? beat + 1'b1 : '0;
      if (busy && zero_r) vd <= old_r;
      else if (busy) vd[beat*BW +: BW] <= res;
    end
  // operands are frozen at acceptance so later input changes cannot disturb the operation in flight
  always_ff @(posedge clk)
    if (acc) begin
      op_r <= op;
      opd_r <= opd_sel;
      sew_r <= sew;
      vm_r <= vm;
      evl_r <= vl > vlmax ? vlmax : vl;
      zero_r <= vl == '0;
      vs1_r <= vs1;
      vs2_r <= vs2;
      old_r <= vd_old;
      v0_r <= v0;
      rs1_r <= rs1;
      imm_r <= imm5;
    end
  for (genvar s = 0; s < 3; s++) begin : g_sew
    localparam int W = 8 << s;
    localparam int N = BW / W;
    for (genvar j = 0; j < N; j++) begin : g_el
      logic [W-1:0] a, b, r;
      logic [IW-1:0] idx;
      assign a = a_s[j*W +: W];
      assign b = opd_r == 2'b01 ? rs1_r[W-1:0] : opd_r == 2'b10 ? {{(W-5){imm_r[4]}}, imm_r} : b_s[j*W +: W];
      assign r = op_r == 3'd0 ? a + b :
                 op_r == 3'd1 ? a - b :
                 op_r == 3'd2 ? a & b :
                 op_r == 3'd3 ? a | b :
                 op_r == 3'd4 ? a ^ b :
                 op_r == 3'd5 ? (a < b ? a : b) :
                 op_r == 3'd6 ? (a < b ? b : a) :
                 a << b[$clog2(W)-1:0];
      assign idx = IW'(beat * N + j);
      assign r_w[s][j*W +: W] = idx < IW'(evl_r) && (vm_r || v0_r[idx]) ? r : o_s[j*W +: W];
    end
  end
endmodule

// File: tb/tb_vlane_alu_seq.sv
// tb_vlane_alu_seq: directed vector table, randomized ops against an element-level model, and handshake corner cases
module tb_vlane_alu_seq;
  logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [2:0] op;
  logic [1:0] opd_sel, sew;
  logic vm;
  logic [4:0] vl;
  logic [127:0] vs1, vs2, vd_old, v0, vd;
  logic [31:0] rs1;
  logic [4:0] imm5;
  logic busy, done;
  int checks = 0, errors = 0;

  typedef struct {
    logic [2:0] op; logic [1:0] opd, sew; logic vm; logic [4:0] vl;
    logic [127:0] vs1, vs2, old, v0; logic [31:0] rs1; logic [4:0] imm;
    logic [127:0] exp; int lat;
  } vec_t;

  vlane_alu_seq #(.VLEN(128), .ELEN(32), .LANES(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .opd_sel(opd_sel), .sew(sew),
    .vm(vm), .vl(vl), .vs1(vs1), .vs2(vs2), .vd_old(vd_old), .v0(v0), .rs1(rs1),
    .imm5(imm5), .busy(busy), .done(done), .vd(vd)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [2:0] o, input logic [1:0] d, input logic [1:0] s,
                              input logic m, input logic [4:0] l, input logic [127:0] a1,
                              input logic [127:0] a2, input logic [127:0] ol, input logic [127:0] msk,
                              input logic [31:0] r, input logic [4:0] im, input logic [127:0] e, input int lt);
    vec_t v;
    v.op = o; v.opd = d; v.sew = s; v.vm = m; v.vl = l; v.vs1 = a1; v.vs2 = a2;
    v.old = ol; v.v0 = msk; v.rs1 = r; v.imm = im; v.exp = e; v.lat = lt;
    return v;
  endfunction

  // element-by-element reference using plain integer arithmetic modulo 2^SEW
  function automatic logic [127:0] model(input vec_t v);
    int w = v.sew == 2'd0 ? 8 : v.sew == 2'd1 ? 16 : 32;
    int n = 128 / w;
    int evl = int'(v.vl) > n ? n : int'(v.vl);
    longint unsigned mm = (64'd1 << w) - 1;
    logic [127:0] m = (128'd1 << w) - 1;
    logic [127:0] r = v.old;
    for (int i = 0; i < evl; i++) begin
      if (v.vm || v.v0[i]) begin
        longint unsigned a, b, x;
        a = 64'((v.vs2 >> (i * w)) & m);
        b = v.opd == 2'd1 ? (64'(v.rs1) & mm) :
            v.opd == 2'd2 ? (64'($signed(v.imm)) & mm) : 64'((v.vs1 >> (i * w)) & m);
        case (v.op)
          3'd0: x = a + b;
          3'd1: x = a - b;
          3'd2: x = a & b;
          3'd3: x = a | b;
          3'd4: x = a ^ b;
          3'd5: x = a < b ? a : b;
          3'd6: x = a < b ? b : a;
          default: x = a << (b % longint'(w));
        endcase
        r = (r & ~(m << (i * w))) | (128'(x & mm) << (i * w));
      end
    end
    return r;
  endfunction

  task automatic drive(input vec_t v);
    op = v.op; opd_sel = v.opd; sew = v.sew; vm = v.vm; vl = v.vl;
    vs1 = v.vs1; vs2 = v.vs2; vd_old = v.old; v0 = v.v0; rs1 = v.rs1; imm5 = v.imm;
  endtask

  // called at a falling edge; returns at the falling edge where done is seen (or the bound expires)
  task automatic run_op(input vec_t v, input string nm);
    int cnt = 0;
    drive(v);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({nm, " busy"}, busy, 1'b1);
    while (!done && cnt < 8) begin
      @(negedge clk);
      cnt++;
    end
    chk({nm, " latency"}, cnt, v.lat);
    chk({nm, " vd"}, vd, v.exp);
  endtask

  initial begin
    vec_t tbl[8];
    vec_t v;
    int cnt;
    logic seen;
    tbl[0] = mk(3'd0, 2'd0, 2'd2, 1'b1, 5'd4, {32'd1, 32'd30, 32'd20, 32'd10},
                {32'hFFFFFFFF, 32'd3, 32'd2, 32'd1}, '0, '0, 32'd0, 5'd0,
                {32'd0, 32'd33, 32'd22, 32'd11}, 2);
    tbl[1] = mk(3'd1, 2'd1, 2'd0, 1'b1, 5'd16, '0, {16{8'h03}}, '0, '0, 32'h5, 5'd0,
                {16{8'hFE}}, 2);
    tbl[2] = mk(3'd0, 2'd2, 2'd1, 1'b0, 5'd8, '0, '0, {8{16'h1234}}, 128'h00AA, 32'd0, 5'h1F,
                {4{16'hFFFF, 16'h1234}}, 2);
    tbl[3] = mk(3'd6, 2'd0, 2'd2, 1'b1, 5'd2, {32'd0, 32'd0, 32'd1, 32'd9},
                {32'd7, 32'd7, 32'h80000000, 32'd5}, {4{32'hDEADBEEF}}, '0, 32'd0, 5'd0,
                {32'hDEADBEEF, 32'hDEADBEEF, 32'h80000000, 32'd9}, 2);
    tbl[4] = mk(3'd0, 2'd0, 2'd2, 1'b1, 5'd0, {4{32'h11111111}}, {4{32'h22222222}},
                128'h0123456789ABCDEF_FEDCBA9876543210, '0, 32'd0, 5'd0,
                128'h0123456789ABCDEF_FEDCBA9876543210, 1);
    tbl[5] = mk(3'd0, 2'd0, 2'd2, 1'b1, 5'd20, {32'd40, 32'd30, 32'd20, 32'd10},
                {32'd4, 32'd3, 32'd2, 32'd1}, {4{32'hCAFEF00D}}, '0, 32'd0, 5'd0,
                {32'd44, 32'd33, 32'd22, 32'd11}, 2);
    tbl[6] = mk(3'd5, 2'd1, 2'd1, 1'b1, 5'd8, '0, {4{16'h0009, 16'h0003}}, '0, '0, 32'h00010005, 5'd0,
                {4{16'h0005, 16'h0003}}, 2);
    tbl[7] = mk(3'd7, 2'd2, 2'd0, 1'b1, 5'd16, '0, {16{8'h81}}, '0, '0, 32'd0, 5'd1,
                {16{8'h02}}, 2);
    drive(tbl[0]);
    repeat (2) @(negedge clk);
    chk("reset busy", busy, 1'b0);
    chk("reset done", done, 1'b0);
    chk("reset vd", vd, '0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i], $sformatf("vec%0d", i));
      @(negedge clk);
      chk($sformatf("vec%0d done pulse", i), done, 1'b0);
      chk($sformatf("vec%0d idle", i), busy, 1'b0);
    end
    for (int i = 0; i < 40; i++) begin
      v = mk(3'($urandom), 2'($urandom), 2'($urandom), 1'($urandom), 5'($urandom_range(0, 20)),
             {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
             {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
             $urandom, 5'($urandom), '0, 0);
      v.exp = model(v);
      v.lat = v.vl == 5'd0 ? 1 : 2;
      run_op(v, $sformatf("rand%0d", i));
      @(negedge clk);
    end
    run_op(tbl[0], "b2b first");
    run_op(tbl[3], "b2b second");
    @(negedge clk);
    chk("b2b done pulse", done, 1'b0);
    drive(tbl[0]);
    start = 1'b1;
    @(negedge clk);
    drive(tbl[2]);
    @(negedge clk);
    start = 1'b0;
    cnt = 1;
    while (!done && cnt < 8) begin
      @(negedge clk);
      cnt++;
    end
    chk("ignored start latency", cnt, 2);
    chk("ignored start vd", vd, tbl[0].exp);
    @(negedge clk);
    chk("ignored start idle", busy, 1'b0);
    drive(tbl[1]);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midreset busy", busy, 1'b0);
    chk("midreset vd", vd, '0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen = seen | done;
    end
    chk("midreset no done", seen, 1'b0);
    chk("midreset vd held", vd, '0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/vlane_alu_seq.md
# vlane_alu_seq

Multi-beat vector integer ALU sequencer: the parametrised successor to the fixed four-lane, 32-bit-element vector execution path. It strip-mines one VLEN-bit vector operation over LANES×ELEN bits per cycle, with selectable SEW (8/16/32) and vv/vx/vi operand modes. It also supports v0 masking and vl tail handling, which keep inactive and tail elements undisturbed. It sits between the vector register file read ports and the VRF write-back mux, under a start/busy/done handshake from the vector control unit.

## Interface
- VLEN, 128, vector register width in bits
- ELEN, 32, maximum element width and lane width in bits
- LANES, 2, lanes per beat; VLEN must be divisible by LANES×ELEN. BEATS = VLEN/(LANES×ELEN).

Ports:
- clk  in  1  single clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  operation request; accepted only when busy=0
- op  in  3  000 add, 001 sub (vs2−opnd), 010 and, 011 or, 100 xor, 101 minu, 110 maxu, 111 sll
- opd_sel  in  2  00 vv (vs1), 01 vx (rs1), 10 vi (imm5), 11 treated as vv
- sew  in  2  00 8-bit, 01 16-bit, 10/11 32-bit
- vm  in  1  1 = unmasked, 0 = masked by v0
- vl  in  $clog2(VLEN/8)+1  active element count
- vs1, vs2, vd_old, v0  in  VLEN  source operands, old destination, mask register
- rs1  in  ELEN  scalar operand
- imm5  in  5  signed immediate
- busy  out  1  operation in progress
- done  out  1  one-cycle completion pulse
- vd  out  VLEN  result register

## Operation
- All inputs except clk/rst_n are captured into internal registers at the edge where start=1 and busy=0. Inputs are ignored at all other times.
- VLMAX = VLEN/SEW. The effective vl is min(vl, VLMAX).
- Element i is active iff i < effective vl and (vm=1 or v0[i]=1). Inactive and tail elements take vd_old's element i.
- Operand selection:
  - vx: rs1 truncated to its low SEW bits.
  - vi: imm5 sign-extended to SEW.
  - vv: element i of vs1.
- Arithmetic is per element, modulo 2^SEW, with no carry or borrow across element boundaries.
- minu/maxu compare unsigned.
- sll shifts vs2 left by the operand's low log2(SEW) bits.
- Beat b covers bits [b×LANES×ELEN +: LANES×ELEN], i.e. LANES×ELEN/SEW elements. Its results are written into vd for that slice only.
- FSM has two states:
  - IDLE → RUN on an accepted start, with beat counter = 0.
  - In RUN, each cycle writes one beat slice and increments the counter.
  - On the last beat (counter = BEATS−1), return to IDLE.
- Effective vl = 0: no beats execute. vd is loaded with vd_old in one cycle and done pulses.

## Timing
- Reset (asynchronous assert, synchronous-safe deassert): busy=0, done=0, vd=0, FSM=IDLE, beat counter=0.
- Start accepted at edge E0:
  - busy=1 from E0 until E_BEATS.
  - Slice b is written at edge E(b+1).
  - done=1 for exactly one cycle, registered at E_BEATS together with the last slice.
  - busy=0 from E_BEATS.
- Latency is BEATS cycles from start to done; for vl=0 it is 1 cycle.
- A start in the cycle done=1 is accepted (back-to-back issue, no bubble).
- A start while busy=1 is ignored and does not corrupt the operation in flight.
- vd holds its last value between operations. During RUN, un-written slices hold their previous value.
- rst_n low mid-operation: immediately busy=0, vd=0, no done pulse. The operation is abandoned.

## Test plan
All cases use VLEN=128, ELEN=32, LANES=2.
- vadd.vv, SEW32, vl=4, vm=1; vs2={1,2,3,0xFFFFFFFF}, vs1={10,20,30,1} -> vd={11,22,33,0}; done exactly 2 cycles after start; busy high those 2 cycles.
- vsub.vx, SEW8, vl=16; every vs2 byte 0x03, rs1=0x00000005 -> every vd byte 0xFE (no cross-byte borrow).
- vadd.vi, SEW16, vl=8, vm=0, v0=0x00AA, imm5=0x1F; vs2 all 0; vd_old halfwords all 0x1234 -> odd elements 0xFFFF, even elements 0x1234.
- vmaxu.vv, SEW32, vl=2; vs2={5,0x80000000,7,7}, vs1={9,1,0,0}, vd_old all 0xDEADBEEF -> vd={9,0x80000000,0xDEADBEEF,0xDEADBEEF}.
- Boundary vl values:
  - vl=0 -> vd=vd_old, done 1 cycle after start.
  - SEW32 with vl=20 -> clamped to 4, all elements active.
- Start pulsed again during beat 0 -> ignored, first result correct. Then rst_n low during beat 1 -> busy=0, vd=0, no done.
